serial_sub: RTL
===============

Name: serial_sub

Overview:
- Bit-serial subtractor: computes diff = a - b, LSB-first, one bit per clock, through a single full-subtractor cell and a borrow flip-flop.
- Counterpart of the team's bit-serial adder; used wherever the datapath needs the inverse operation at minimal area.
- Has an internal load/shift/done FSM with a start/busy/done handshake, so no external sequencing of load or shift strobes is needed.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- The shift counter width is derived internally: enough bits to count to WIDTH.

Ports:
- clk    input   1      rising-edge clock
- clear  input   1      asynchronous active-low reset
- start  input   1      request; sampled in IDLE or DONE only
- a      input   WIDTH  minuend, sampled on the accepted start edge
- b      input   WIDTH  subtrahend, sampled on the accepted start edge
- busy   output  1      high while in SHIFT
- done   output  1      one-cycle completion pulse
- diff   output  WIDTH  registered result, (a - b) mod 2^WIDTH
- bout   output  1      registered final borrow; 1 when a < b unsigned

Behaviour:
- Reset: clear low forces state=IDLE and zeroes the A/B shift registers, borrow FF, counter, busy, done, diff and bout, asynchronously.
- Reset mid-operation aborts the operation: no done pulse, and diff/bout read 0.
- States: IDLE, SHIFT, DONE.
- IDLE or DONE with start=1 at edge E0:
  - load Areg<=a, Breg<=b, borrow<=0, cnt<=0; go to SHIFT.
  - DONE with start=1 at that edge loads directly; done is still low after E0 (back-to-back operation is legal).
- SHIFT, each edge:
  - d = A0^B0^br
  - br_next = (~A0&B0) | (~A0&br) | (B0&br)
  - Areg <= {d, Areg[WIDTH-1:1]}; Breg <= {1'b0, Breg[WIDTH-1:1]}; borrow <= br_next; cnt <= cnt+1.
- On the edge completing the WIDTH-th shift (E_WIDTH):
  - diff <= {d, Areg[WIDTH-1:1]}; bout <= br_next.
  - state -> DONE.
- DONE:
  - done=1 for exactly one cycle, between E_WIDTH and E_WIDTH+1.
  - Without start, go to IDLE at the next edge.
- Latency: done is high in the cycle after the WIDTH-th edge following the start edge (WIDTH=4: cycle after the 4th edge).
- busy=1 for exactly WIDTH cycles per operation.
- start while busy is ignored; the in-flight operation and inputs are unaffected.
- a/b changing after the start edge have no effect.
- diff/bout hold their value until the next completion or reset, including throughout a subsequent operation.
- Wrap-around: the result is modulo 2^WIDTH. bout=1 exactly when a<b unsigned; a==b gives diff=0, bout=0.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered, reset 0.
  - ovf <= (a[MSB] != b[MSB]) && (diff_new[MSB] != a[MSB]), using operand MSBs captured at load.
  - ovf is updated on the same edge as diff and held with it.
- Undefined: port ovf is absent and there is no extra logic; all other behaviour is identical.

Test Plan:
1. WIDTH=4, a=0100, b=0001, start pulse -> busy for 4 cycles; done in the cycle after the 4th edge; diff=0011, bout=0.
2. a=0001, b=0100 -> diff=1101, bout=1. Then a=1111, b=1111 -> diff=0000, bout=0. Then a=0000, b=0001 -> diff=1111, bout=1.
3. Start 0100-0001, then re-assert start with a=1111, b=0000 on cycle 2 of SHIFT -> ignored; diff=0011 and a single done pulse.
4. Hold start high continuously:
   - back-to-back operations; the reload edge (E_WIDTH+1) coincides with the done cycle.
   - done pulses once per operation, 5 cycles apart.
   - diff holds the previous result during the second operation.
5. clear low for 1 cycle during SHIFT cycle 2 -> busy=0, done never pulses, diff=0, bout=0; a following start with 0110-0011 gives diff=0011.
6. With SERIAL_SUB_SIGNED_OVF_EN defined:
   - 0111-1111 -> diff=1000, bout=1, ovf=1.
   - 0100-0001 -> ovf=0.
   - 1000-0001 -> diff=0111, ovf=1.

Source files
------------

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module serial_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              br_q, br_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              d_bit;
  logic              br_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic              a_msb_q, a_msb_d;
  logic              b_msb_q, b_msb_d;
  logic              ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br_q) | (b_q[0] & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StShift;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        a_d   = {d_bit, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          diff_d  = {d_bit, a_q[WIDTH-1:1]};
          bout_d  = br_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          // Overflow only possible when operand signs differ.
          ovf_d = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
